// File: rtl/lsu_dmem_adapter.sv
// LSU-to-RAM adapter: maps B/H/W/D loads and stores onto 64-bit dword RAM beats,
// splitting dword-crossing accesses into two beats and extending load data.

module lsu_dmem_lane (
  input  logic       en,
  input  logic       be,
  input  logic [7:0] wbyte,
  output logic [7:0] mask,
  output logic [7:0] wdata
);
  assign mask  = {8{en & be}};
  assign wdata = en ? wbyte : 8'h00;
endmodule

module lsu_dmem_adapter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_split,
  output logic        dmem_en,
  output logic [63:0] dmem_addr,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] dmem_wdata,
  output logic [63:0] dmem_wmask,
  output logic        dmem_wen
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic        sgn;
    logic [63:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [63:0] buf_q, buf_nxt;

  // Keeps the low 2^sz bytes, extending from the top kept byte when sgn is set.
  function automatic logic [63:0] fit(input logic [63:0] d, input logic [1:0] sz,
                                      input logic sgn);
    logic s;
    s = 1'b0;
    case (sz)
      2'd0: begin s = sgn & d[7];  fit = {{56{s}}, d[7:0]};  end
      2'd1: begin s = sgn & d[15]; fit = {{48{s}}, d[15:0]}; end
      2'd2: begin s = sgn & d[31]; fit = {{32{s}}, d[31:0]}; end
      default: fit = d;
    endcase
  endfunction

  logic [2:0]  off;
  logic [3:0]  nbytes;
  logic [15:0] bmask;
  logic        split;
  logic [5:0]  lo_sh;
  logic [6:0]  hi_sh;

  assign off    = req_q.addr[2:0];
  assign nbytes = 4'd1 << req_q.size;
  assign bmask  = ((16'd1 << nbytes) - 16'd1) << off;
  assign split  = ({1'b0, off} + nbytes) > 4'd8;
  assign lo_sh  = {off, 3'b000};
  assign hi_sh  = 7'd64 - {1'b0, lo_sh};

  logic                 beat_en, beat_wen;
  logic [63:0]          beat_addr, beat_wdata;
  logic [NUM_LANES-1:0] beat_be;

  always_comb begin
    state_nxt  = state;
    buf_nxt    = buf_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 64'd0;
    resp_split = 1'b0;
    beat_en    = 1'b0;
    beat_wen   = 1'b0;
    beat_addr  = 64'd0;
    beat_wdata = 64'd0;
    beat_be    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BEAT0;
      end
      BEAT0: begin
        beat_en    = 1'b1;
        beat_wen   = req_q.wen;
        beat_addr  = {req_q.addr[63:3], 3'b000};
        beat_be    = bmask[7:0];
        beat_wdata = req_q.wdata << lo_sh;
        buf_nxt    = dmem_rdata >> lo_sh;
        state_nxt  = split ? BEAT1 : RESP;
      end
      BEAT1: begin
        beat_en    = 1'b1;
        beat_wen   = req_q.wen;
        beat_addr  = {req_q.addr[63:3], 3'b000} + 64'd8;
        beat_be    = bmask[15:8];
        beat_wdata = req_q.wdata >> hi_sh;
        buf_nxt    = buf_q | (dmem_rdata << hi_sh);
        state_nxt  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = req_q.wen ? 64'd0 : fit(buf_q, req_q.size, req_q.sgn);
        resp_split = split;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte enables fan out to bit masks lane by lane; everything is zero outside a beat.
  logic [NUM_LANES-1:0][7:0] lane_mask, lane_wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_dmem_lane u_lane (
      .en    (beat_en),
      .be    (beat_be[i]),
      .wbyte (beat_wdata[8*i +: 8]),
      .mask  (lane_mask[i]),
      .wdata (lane_wdata[i])
    );
  end

  assign dmem_en    = beat_en;
  assign dmem_wen   = beat_wen;
  assign dmem_addr  = beat_addr;
  assign dmem_wmask = lane_mask;
  assign dmem_wdata = lane_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_q <= '0;
      buf_q <= 64'd0;
    end else begin
      state <= state_nxt;
      buf_q <= buf_nxt;
      if (req_valid && req_ready)
        req_q <= '{addr: req_addr, size: req_size, wen: req_wen, sgn: req_signed,
                   wdata: fit(req_wdata, req_size, 1'b0)};
    end
  end
endmodule

// File: tb/tb_lsu_dmem_adapter.sv
// Bench for lsu_dmem_adapter: byte-level reference model plus directed vectors
// with hand-computed beats and load results.

module tb_lsu_dmem_adapter;
  localparam logic [63:0] INIT0 = 64'h8877_6655_4433_2211;
  localparam logic [63:0] INIT1 = 64'hFFEE_DDCC_BBAA_9900;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_ready, resp_valid, resp_split, dmem_en, dmem_wen;
  logic [63:0] resp_rdata, dmem_addr, dmem_rdata, dmem_wdata, dmem_wmask;

  lsu_dmem_adapter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_split(resp_split),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen)
  );

  always #5 clk = ~clk;

  // RAM: 16 dwords from 0x8000_0000, combinational read, masked write at posedge.
  logic [63:0] ram [0:15];
  assign dmem_rdata = ram[dmem_addr[6:3]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 64'd0;
      ram[0] <= INIT0;
      ram[1] <= INIT1;
    end else if (dmem_en && dmem_wen) begin
      ram[dmem_addr[6:3]] <= (ram[dmem_addr[6:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
    end
  end

  // Reference model: byte memory, queue of expected beats, pending response.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic        wen;
  } beat_t;

  logic [7:0]  ref_mem [0:127];
  beat_t       bq [$];
  logic        m_resp = 1'b0, m_split = 1'b0;
  logic [63:0] m_rdata = 64'd0;

  always @(posedge clk or posedge reset) begin : model
    beat_t       b;
    beat_t       bb [2];
    logic [63:0] v;
    int          nb, off, p;
    if (preload) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        ref_mem[i]     = INIT0[8*i +: 8];
        ref_mem[8 + i] = INIT1[8*i +: 8];
      end
    end
    if (reset) begin
      bq.delete();
      m_resp = 1'b0;
    end else if (bq.size() > 0) begin
      b = bq.pop_front();
      if (b.wen)
        for (int k = 0; k < 8; k++)
          if (b.mask[8*k]) ref_mem[b.addr[6:0] + 7'(k)] = b.wdata[8*k +: 8];
    end else if (m_resp) begin
      if (resp_ready) m_resp = 1'b0;
    end else if (req_valid) begin
      nb  = 1 << int'(req_size);
      off = int'(req_addr[2:0]);
      for (int j = 0; j < 2; j++) begin
        bb[j].addr  = {req_addr[63:3], 3'b000} + 64'(8 * j);
        bb[j].mask  = 64'd0;
        bb[j].wdata = 64'd0;
        bb[j].wen   = req_wen;
      end
      v = 64'd0;
      for (int i = 0; i < nb; i++) begin
        p = off + i;
        bb[p / 8].mask[8*(p % 8) +: 8]  = 8'hFF;
        bb[p / 8].wdata[8*(p % 8) +: 8] = req_wdata[8*i +: 8];
        v[8*i +: 8] = ref_mem[req_addr[6:0] + 7'(i)];
      end
      if (req_signed && v[8*nb - 1])
        for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      if (req_wen) v = 64'd0;
      bq.push_back(bb[0]);
      if (off + nb > 8) bq.push_back(bb[1]);
      m_resp  = 1'b1;
      m_rdata = v;
      m_split = (off + nb > 8);
    end
  end

  // Hand-computed literals, consumed in order by the compare process.
  int          lit_n = 0;
  int          lit_kind [0:31];
  logic [63:0] lit_a [0:31], lit_b [0:31], lit_c [0:31];
  int          to_cnt = 0;
  logic        done = 1'b0;

  task automatic lit_beat(input logic [63:0] a, input logic [63:0] m, input logic [63:0] w);
    lit_kind[lit_n] = 0; lit_a[lit_n] = a; lit_b[lit_n] = m; lit_c[lit_n] = w;
    lit_n++;
  endtask

  task automatic lit_resp(input logic [63:0] d, input logic s);
    lit_kind[lit_n] = 1; lit_a[lit_n] = d; lit_b[lit_n] = {63'd0, s}; lit_c[lit_n] = 64'd0;
    lit_n++;
  endtask

  int   n_pass = 0, n_tot = 0, lit_rd = 0;
  logic lit_resp_act = 1'b0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
  endtask

  task automatic chk_b(input string nm, input logic a, input logic e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
  endtask

  task automatic dmem_idle(input string ph);
    chk_b({ph, "_dmem_en"}, dmem_en, 1'b0);
    chk_b({ph, "_dmem_wen"}, dmem_wen, 1'b0);
    chk({ph, "_dmem_addr"}, dmem_addr, 64'd0);
    chk({ph, "_dmem_wmask"}, dmem_wmask, 64'd0);
    chk({ph, "_dmem_wdata"}, dmem_wdata, 64'd0);
  endtask

  always @(negedge clk) begin : cmp
    if (lit_resp_act && (reset || !m_resp || bq.size() > 0)) begin
      lit_rd++;
      lit_resp_act = 1'b0;
    end
    if (reset) begin
      chk_b("rst_req_ready", req_ready, 1'b1);
      chk_b("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk_b("rst_resp_split", resp_split, 1'b0);
      dmem_idle("rst");
    end else if (bq.size() > 0) begin
      chk_b("beat_req_ready", req_ready, 1'b0);
      chk_b("beat_resp_valid", resp_valid, 1'b0);
      chk_b("beat_dmem_en", dmem_en, 1'b1);
      chk_b("beat_dmem_wen", dmem_wen, bq[0].wen);
      chk("beat_dmem_addr", dmem_addr, bq[0].addr);
      chk("beat_dmem_wmask", dmem_wmask, bq[0].mask);
      chk("beat_dmem_wdata", dmem_wdata, bq[0].wdata);
      if (lit_rd < lit_n && lit_kind[lit_rd] == 0) begin
        chk("lit_beat_addr", dmem_addr, lit_a[lit_rd]);
        chk("lit_beat_wmask", dmem_wmask, lit_b[lit_rd]);
        chk("lit_beat_wdata", dmem_wdata, lit_c[lit_rd]);
        lit_rd++;
      end
    end else if (m_resp) begin
      chk_b("resp_req_ready", req_ready, 1'b0);
      chk_b("resp_valid", resp_valid, 1'b1);
      chk("resp_rdata", resp_rdata, m_rdata);
      chk_b("resp_split", resp_split, m_split);
      dmem_idle("resp");
      if (lit_rd < lit_n && lit_kind[lit_rd] == 1) begin
        chk("lit_resp_rdata", resp_rdata, lit_a[lit_rd]);
        chk_b("lit_resp_split", resp_split, lit_b[lit_rd][0]);
        lit_resp_act = 1'b1;
      end
    end else begin
      chk_b("idle_req_ready", req_ready, 1'b1);
      chk_b("idle_resp_valid", resp_valid, 1'b0);
      dmem_idle("idle");
    end
    if (done) begin
      chk("no_timeout", 64'(to_cnt), 64'd0);
      chk("literals_consumed", 64'(lit_rd), 64'(lit_n));
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
    end
  end

  task automatic send(input logic wen, input logic [63:0] a, input logic [1:0] sz,
                      input logic sgn, input logic [63:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_size = sz;
    req_signed = sgn; req_wdata = wd;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) to_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = 64'd0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) to_cnt++;
  endtask

  task automatic xact(input logic wen, input logic [63:0] a, input logic [1:0] sz,
                      input logic sgn, input logic [63:0] wd);
    send(wen, a, sz, sgn, wd);
    wait_resp();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 preload = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    lit_beat(64'h8000_0000, 64'hFF00_0000_0000_0000, 64'h0);
    lit_resp(64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    xact(1'b0, 64'h8000_0007, 2'd0, 1'b1, 64'h0);

    lit_beat(64'h8000_0000, 64'hFFFF_0000_0000_0000, 64'h0);
    lit_beat(64'h8000_0008, 64'h0000_0000_0000_FFFF, 64'h0);
    lit_resp(64'h0000_0000_9900_8877, 1'b1);
    xact(1'b0, 64'h8000_0006, 2'd2, 1'b0, 64'h0);

    lit_beat(64'h8000_0000, 64'h0000_00FF_FF00_0000, 64'h0000_00AB_CD00_0000);
    lit_resp(64'h0, 1'b0);
    xact(1'b1, 64'h8000_0003, 2'd1, 1'b0, 64'h1234_ABCD);
    lit_resp(64'h8877_66AB_CD33_2211, 1'b0);
    xact(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'h0);

    lit_beat(64'h8000_0000, 64'hFFFF_FFFF_0000_0000, 64'h0506_0708_0000_0000);
    lit_beat(64'h8000_0008, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0102_0304);
    lit_resp(64'h0, 1'b1);
    xact(1'b1, 64'h8000_0004, 2'd3, 1'b0, 64'h0102_0304_0506_0708);

    lit_resp(64'hCC01_0203_0405_0607, 1'b1);
    xact(1'b0, 64'h8000_0005, 2'd3, 1'b0, 64'h0);
    lit_resp(64'hFFFF_FFFF_FFFF_DDCC, 1'b0);
    xact(1'b0, 64'h8000_000C, 2'd1, 1'b1, 64'h0);
    lit_resp(64'hFFFF_FFFF_FFEE_DDCC, 1'b0);
    xact(1'b0, 64'h8000_000C, 2'd2, 1'b1, 64'h0);
    lit_resp(64'h0000_0000_0000_00FF, 1'b0);
    xact(1'b0, 64'h8000_000F, 2'd0, 1'b0, 64'h0);

    // Response held off for five cycles, handshake in the sixth.
    resp_ready = 1'b0;
    lit_resp(64'h0506_0708_CD33_2211, 1'b0);
    send(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'h0);
    wait_resp();
    repeat (5) @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset lands in BEAT1 of a split store: only the first half sticks.
    lit_beat(64'h8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hB1B2_B3B4_0000_0000);
    send(1'b1, 64'h8000_0004, 2'd3, 1'b0, 64'hA1A2_A3A4_B1B2_B3B4);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    lit_resp(64'hB1B2_B3B4_CD33_2211, 1'b0);
    xact(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'h0);
    lit_resp(64'hFFEE_DDCC_0102_0304, 1'b0);
    xact(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'h0);

    repeat (2) @(posedge clk);
    #1 done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL summary_not_reached: got none expected summary");
    $fatal(1);
  end
endmodule
